fnd_scan_ctrl: RTL and testbench

FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

---
 rtl/fnd_scan_ctrl.sv | 108 ++++++++++
 tb/tb_fnd_scan_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scan controller with per-frame snapshot.
// Optional leading-zero blanking is enabled by defining FND_BLANK_EN.
module fnd_scan_ctrl #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic [15:0] value,
  input  logic [3:0]  dp_en,
  input  logic        disp_en,
  output logic [7:0]  seg_7,
  output logic [3:0]  com
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      snap_val_q, snap_val_d;
  logic [3:0]       snap_dp_q, snap_dp_d;
  logic [3:0]       com_q, com_d;
  logic [7:0]       seg_q, seg_d;
  logic             tick;
  logic [3:0]       nibble;
  logic             dp_bit;
  logic             blank;
  logic [6:0]       glyph;

  // Active-low a..g pattern for a hex nibble.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  assign tick   = (cnt_q == CNT_MAX);
  assign nibble = snap_val_q[idx_q*4 +: 4];
  assign dp_bit = snap_dp_q[idx_q];

`ifdef FND_BLANK_EN
  // zero_from[i]: nibble i and every higher nibble are zero.
  logic [3:0] zero_from;
  for (genvar gi = 0; gi < 4; gi++) begin : g_zero
    assign zero_from[gi] = (snap_val_q[15:4*gi] == '0);
  end
  assign blank = (idx_q != 2'd0) && zero_from[idx_q];
`else
  assign blank = 1'b0;
`endif

  assign glyph = blank ? 7'h7F : hex_glyph(nibble);

  always_comb begin
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
    snap_val_d = snap_val_q;
    snap_dp_d  = snap_dp_q;
    com_d      = 4'hF;
    seg_d      = 8'hFF;
    // A new frame's data is taken only as digit 3 hands over to digit 0.
    if (tick && idx_q == 2'd3) begin
      snap_val_d = value;
      snap_dp_d  = dp_en;
    end
    if (disp_en) begin
      com_d = ~(4'b0001 << idx_q);
      seg_d = {~dp_bit, glyph};
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      snap_val_q <= 16'h0000;
      snap_dp_q  <= 4'h0;
      com_q      <= 4'hF;
      seg_q      <= 8'hFF;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      snap_val_q <= snap_val_d;
      snap_dp_q  <= snap_dp_d;
      com_q      <= com_d;
      seg_q      <= seg_d;
    end
  end

  assign com   = com_q;
  assign seg_7 = seg_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl at SCAN_DIV=4, plus a SCAN_DIV=1 instance.
// Expectations track FND_BLANK_EN when it is defined for the build.
module tb_fnd_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_p;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic        disp_en;
  logic [7:0]  seg_7, seg_7_f;
  logic [3:0]  com, com_f;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

`ifdef FND_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  always #5 clk = ~clk;

  fnd_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset_p(reset_p), .value(value), .dp_en(dp_en),
    .disp_en(disp_en), .seg_7(seg_7), .com(com)
  );

  fnd_scan_ctrl #(.SCAN_DIV(1)) dut_fast (
    .clk(clk), .reset_p(reset_p), .value(value), .dp_en(dp_en),
    .disp_en(disp_en), .seg_7(seg_7_f), .com(com_f)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
    $display("check %-14s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ecom, input logic [7:0] eseg);
    chk({tag, ".com"}, {4'h0, com}, {4'h0, ecom});
    chk({tag, ".seg"}, seg_7, eseg);
  endtask

  initial begin
    reset_p = 1'b1; value = 16'h0000; dp_en = 4'h0; disp_en = 1'b1;
    step(); step();
    chk_out("reset", 4'hF, 8'hFF);
    chk("fast_reset", {4'h0, com_f}, 8'h0F);

    // Release reset; edges are now counted from 1.
    reset_p = 1'b0; value = 16'h1234; dp_en = 4'b0100; cyc = 0;
    step();
    chk_out("first", 4'hE, 8'hC0);
    chk("fast_com1", {4'h0, com_f}, 8'h0E);
    step(); chk("fast_com2", {4'h0, com_f}, 8'h0D);
    step(); chk("fast_com3", {4'h0, com_f}, 8'h0B);
    step(); chk("fast_com4", {4'h0, com_f}, 8'h07);
    step(); chk("fast_dig0", seg_7_f, 8'h99);
    run_to(5);  chk_out("frame0_d1", 4'hD, 8'hC0);
    run_to(13); chk_out("frame0_d3", 4'h7, 8'hC0);

    // Snapshot of 1234 at edge 16.
    run_to(17); chk_out("n_d0", 4'hE, 8'h99);
    run_to(21); chk_out("n_d1", 4'hD, 8'hB0);
    run_to(22); value = 16'h5678;
    run_to(25); chk_out("n_d2", 4'hB, 8'h24);
    run_to(29); chk_out("n_d3", 4'h7, 8'hF9);
    run_to(31); chk_out("n_d3_hold", 4'h7, 8'hF9);

    // Snapshot of 5678 at edge 32; disable mid-frame.
    run_to(33); chk_out("m_d0", 4'hE, 8'h80);
    run_to(34); disp_en = 1'b0;
    run_to(35); chk_out("dis", 4'hF, 8'hFF);
    run_to(37); chk_out("dis_hold", 4'hF, 8'hFF);
    run_to(38); disp_en = 1'b1;
    run_to(39); chk_out("reen_d1", 4'hD, 8'hF8);
    run_to(41); chk_out("m_d2", 4'hB, 8'h02);
    run_to(45); chk_out("m_d3", 4'h7, 8'h92);
    value = 16'h0005; dp_en = 4'h0;

    // Snapshot of 0005 at edge 48.
    run_to(49); chk_out("z5_d0", 4'hE, 8'h92);
    run_to(53); chk_out("z5_d1", 4'hD, BLANK ? 8'hFF : 8'hC0);
    run_to(57); chk_out("z5_d2", 4'hB, BLANK ? 8'hFF : 8'hC0);
    run_to(61); chk_out("z5_d3", 4'h7, BLANK ? 8'hFF : 8'hC0);
    value = 16'h0100;

    // Snapshot of 0100 at edge 64.
    run_to(65); chk_out("z1_d0", 4'hE, 8'hC0);
    run_to(69); chk_out("z1_d1", 4'hD, 8'hC0);
    run_to(73); chk_out("z1_d2", 4'hB, 8'hF9);
    run_to(77); chk_out("z1_d3", 4'h7, BLANK ? 8'hFF : 8'hC0);
    value = 16'hABCD; dp_en = 4'b1000;

    // Snapshot of ABCD with dp on digit 3 at edge 80.
    run_to(81); chk_out("h_d0", 4'hE, 8'hA1);
    run_to(85); chk_out("h_d1", 4'hD, 8'hC6);
    run_to(89); chk_out("h_d2", 4'hB, 8'h83);
    run_to(93); chk_out("h_d3", 4'h7, 8'h08);
    run_to(97); chk_out("h2_d0", 4'hE, 8'hA1);
    run_to(105); chk_out("h2_d2", 4'hB, 8'h83);

    // Reset pulse while idx=2.
    reset_p = 1'b1;
    step();
    chk_out("midreset", 4'hF, 8'hFF);
    reset_p = 1'b0; cyc = 0;
    step(); chk_out("post_d0", 4'hE, 8'hC0);
    run_to(4); chk_out("post_d0h", 4'hE, 8'hC0);
    run_to(5); chk_out("post_d1", 4'hD, 8'hC0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
